eig_sched: RTL and testbench

- Round-robin scheduler that shares one eig_core datapath between N_REQ requesters.
- Accepts (a0, a1) coefficient pairs per channel over valid/ready and issues them to the core one at a time.
- Waits for completion, or a watchdog timeout, then returns kappa/inv_kappa/regime tagged with the channel id.
- Sits between the channel front-ends and the single eig_core instance.

---
 rtl/eig_sched_pkg.sv | 17 +
 rtl/eig_sched_if.sv | 55 +++++
 rtl/eig_sched_rr_arbiter.sv | 31 +++
 rtl/eig_sched.sv | 124 ++++++++++++
 tb/tb_eig_sched.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/eig_sched_pkg.sv
// Shared definitions for the eig_core round-robin scheduler.
package eig_sched_pkg;

    // One-hot regime codes reported by eig_core; NONE marks an aborted job.
    localparam logic [2:0] REGIME_OVER  = 3'b100;
    localparam logic [2:0] REGIME_CRIT  = 3'b010;
    localparam logic [2:0] REGIME_UNDER = 3'b001;
    localparam logic [2:0] REGIME_NONE  = 3'b000;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } sched_state_e;

endpackage

// File: rtl/eig_sched_if.sv
// Request, core and result buses of the eig_core scheduler.
interface eig_sched_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 32
);
    localparam int unsigned IDW = $clog2(N_REQ);

    // Channel front-end side
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*W-1:0] req_a0;
    logic [N_REQ*W-1:0] req_a1;

    // eig_core side
    logic               core_data_rdy;
    logic [W-1:0]       core_a0;
    logic [W-1:0]       core_a1;
    logic               core_done;
    logic [W-1:0]       core_kappa;
    logic [W-1:0]       core_inv_kappa;
    logic [2:0]         core_regime;

    // Result side
    logic               res_valid;
    logic               res_ready;
    logic [IDW-1:0]     res_id;
    logic [W-1:0]       res_kappa;
    logic [W-1:0]       res_inv_kappa;
    logic [2:0]         res_regime;
    logic               res_timeout;
    logic               busy;

    // Scheduler view
    modport master (
        input  req_valid, req_a0, req_a1,
        input  core_done, core_kappa, core_inv_kappa, core_regime,
        input  res_ready,
        output req_ready,
        output core_data_rdy, core_a0, core_a1,
        output res_valid, res_id, res_kappa, res_inv_kappa, res_regime, res_timeout,
        output busy
    );

    // Environment view (front-ends, core and result consumer)
    modport slave (
        output req_valid, req_a0, req_a1,
        output core_done, core_kappa, core_inv_kappa, core_regime,
        output res_ready,
        input  req_ready,
        input  core_data_rdy, core_a0, core_a1,
        input  res_valid, res_id, res_kappa, res_inv_kappa, res_regime, res_timeout,
        input  busy
    );

endinterface

// File: rtl/eig_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester above the last grant wins.
module eig_sched_rr_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx
);

    logic           found;
    logic [IDW-1:0] pos;

    // Walk (last+1) .. (last+N) mod N and keep the first active request.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            pos = IDW'((32'(last) + off) % N);
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/eig_sched.sv
// Round-robin scheduler sharing one eig_core between N_REQ channels, with a
// watchdog that aborts a job when the core never signals completion.
module eig_sched
    import eig_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned W       = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input logic         clk,
    input logic         rst,
    eig_sched_if.master bus
);

    localparam int unsigned IDW = $clog2(N_REQ);
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);

    sched_state_e   state_q;
    logic [IDW-1:0] last_q;
    logic [IDW-1:0] id_q;
    logic [TW-1:0]  timer_q;
    logic [W-1:0]   a0_q;
    logic [W-1:0]   a1_q;
    logic [W-1:0]   kappa_q;
    logic [W-1:0]   inv_kappa_q;
    logic [2:0]     regime_q;
    logic           timeout_q;
    logic           data_rdy_q;
    logic           res_valid_q;

    logic [N_REQ-1:0] win_grant;
    logic [IDW-1:0]   win_idx;
    logic             accept;

    eig_sched_rr_arbiter #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_arb (
        .req   (bus.req_valid),
        .last  (last_q),
        .grant (win_grant),
        .idx   (win_idx)
    );

    // Grant is only offered while idle, so at most one job is ever in flight.
    always_comb begin
        bus.req_ready = (state_q == StIdle) ? win_grant : '0;
        accept        = |(bus.req_valid & bus.req_ready);
    end

    assign bus.core_data_rdy = data_rdy_q;
    assign bus.core_a0       = a0_q;
    assign bus.core_a1       = a1_q;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_id        = id_q;
    assign bus.res_kappa     = kappa_q;
    assign bus.res_inv_kappa = inv_kappa_q;
    assign bus.res_regime    = regime_q;
    assign bus.res_timeout   = timeout_q;
    assign bus.busy          = (state_q != StIdle);

    // Scheduler FSM with watchdog timer and registered core/result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            last_q      <= IDW'(N_REQ - 1);
            id_q        <= '0;
            timer_q     <= '0;
            a0_q        <= '0;
            a1_q        <= '0;
            kappa_q     <= '0;
            inv_kappa_q <= '0;
            regime_q    <= REGIME_NONE;
            timeout_q   <= 1'b0;
            data_rdy_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        a0_q       <= bus.req_a0[32'(win_idx) * W +: W];
                        a1_q       <= bus.req_a1[32'(win_idx) * W +: W];
                        id_q       <= win_idx;
                        data_rdy_q <= 1'b1;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    data_rdy_q <= 1'b0;
                    timer_q    <= '0;
                    state_q    <= StWait;
                end
                StWait: begin
                    timer_q <= timer_q + 1'b1;
                    // A done in the last watchdog cycle still counts as a normal result.
                    if (bus.core_done) begin
                        kappa_q     <= bus.core_kappa;
                        inv_kappa_q <= bus.core_inv_kappa;
                        regime_q    <= bus.core_regime;
                        timeout_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        kappa_q     <= '0;
                        inv_kappa_q <= '0;
                        regime_q    <= REGIME_NONE;
                        timeout_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    if (bus.res_ready) begin
                        last_q      <= id_q;
                        res_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_eig_sched.sv
// Self-checking bench for eig_sched with a programmable eig_core stub.
module tb_eig_sched;
    import eig_sched_pkg::*;

    localparam int unsigned NR  = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 16;

    typedef struct {
        logic [3:0]  mask;
        int          delay;   // cycles from core_data_rdy to core_done; <=0 means never
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] kappa;
        logic [31:0] inv;
        logic [2:0]  regime;
        int          exp_id;
    } job_t;

    typedef struct {
        int          id;
        logic [31:0] kappa;
        logic [31:0] inv;
        logic [2:0]  regime;
        logic        timeout;
    } exp_res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    int   stub_delay = 0;
    int   stub_cnt   = 0;
    logic inject     = 1'b0;

    exp_res_t sb[$];
    job_t     tbl[11];

    eig_sched_if #(.N_REQ(NR), .W(DW)) bus ();

    eig_sched #(
        .N_REQ   (NR),
        .W       (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Core stub: pulses done stub_delay cycles after the start pulse, or on inject.
    always @(negedge clk) begin
        bus.core_done = 1'b0;
        if (stub_cnt > 0) begin
            stub_cnt = stub_cnt - 1;
            if (stub_cnt == 0) bus.core_done = 1'b1;
        end
        if (inject) bus.core_done = 1'b1;
        if (bus.core_data_rdy && stub_delay > 0) stub_cnt = stub_delay;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete, got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_core_data_rdy"}, 32'(bus.core_data_rdy), 32'd0);
        chk({tag, "_core_a0"}, bus.core_a0, 32'd0);
        chk({tag, "_core_a1"}, bus.core_a1, 32'd0);
        chk({tag, "_res_id"}, 32'(bus.res_id), 32'd0);
        chk({tag, "_res_kappa"}, bus.res_kappa, 32'd0);
        chk({tag, "_res_inv_kappa"}, bus.res_inv_kappa, 32'd0);
        chk({tag, "_res_regime"}, 32'(bus.res_regime), 32'd0);
        chk({tag, "_res_timeout"}, 32'(bus.res_timeout), 32'd0);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    endtask

    // Runs one job from IDLE (entered at posedge+2); hold keeps res_ready low for 20 cycles.
    task automatic run_job(input job_t j, input bit hold);
        exp_res_t e;
        exp_res_t got;
        bit       tmo;
        int       rdy;
        int       n;
        for (int i = 0; i < int'(NR); i++) begin
            bus.req_a0[i*32 +: 32] = (i == j.exp_id) ? j.a0 : (j.a0 ^ 32'hFFFF_0000);
            bus.req_a1[i*32 +: 32] = (i == j.exp_id) ? j.a1 : (j.a1 ^ 32'h0F0F_0000);
        end
        bus.core_kappa     = j.kappa;
        bus.core_inv_kappa = j.inv;
        bus.core_regime    = j.regime;
        stub_delay         = j.delay;
        bus.res_ready      = !hold;
        bus.req_valid      = j.mask;
        #1;
        chk("req_ready_grant", 32'(bus.req_ready), 32'd1 << j.exp_id);
        tmo       = (j.delay < 1) || (j.delay > int'(TMO));
        e.id      = j.exp_id;
        e.timeout = tmo;
        e.kappa   = tmo ? 32'd0 : j.kappa;
        e.inv     = tmo ? 32'd0 : j.inv;
        e.regime  = tmo ? REGIME_NONE : j.regime;
        sb.push_back(e);

        @(posedge clk); #2;
        bus.req_valid = '0;
        rdy = cyc;
        chk("core_data_rdy_issue", 32'(bus.core_data_rdy), 32'd1);
        chk("core_a0", bus.core_a0, j.a0);
        chk("core_a1", bus.core_a1, j.a1);
        chk("busy_issue", 32'(bus.busy), 32'd1);

        @(posedge clk); #2;
        chk("core_data_rdy_pulse", 32'(bus.core_data_rdy), 32'd0);
        chk("req_ready_busy", 32'(bus.req_ready), 32'd0);

        n = 0;
        while (!bus.res_valid && n < 64) begin
            @(posedge clk); #2;
            n++;
        end
        if (!bus.res_valid) begin
            checks++;
            errors++;
            $display("FAIL res_valid_wait: got no result required result within 64 cycles");
            bus.res_ready = 1'b1;
            return;
        end
        chk("res_latency", 32'(cyc - rdy), tmo ? (TMO + 1) : 32'(j.delay + 1));
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got result required none pending");
            return;
        end
        got = sb.pop_front();
        chk("res_id", 32'(bus.res_id), 32'(got.id));
        chk("res_kappa", bus.res_kappa, got.kappa);
        chk("res_inv_kappa", bus.res_inv_kappa, got.inv);
        chk("res_regime", 32'(bus.res_regime), 32'(got.regime));
        chk("res_timeout", 32'(bus.res_timeout), 32'(got.timeout));

        if (hold) begin
            bus.req_valid = 4'hF;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #2;
                if (k == 3) begin
                    inject             = 1'b1;
                    bus.core_kappa     = 32'hDEAD_BEEF;
                    bus.core_inv_kappa = 32'hBEEF_DEAD;
                    bus.core_regime    = REGIME_CRIT;
                end
                if (k == 4) inject = 1'b0;
                chk("hold_res_valid", 32'(bus.res_valid), 32'd1);
                chk("hold_res_id", 32'(bus.res_id), 32'(got.id));
                chk("hold_res_kappa", bus.res_kappa, got.kappa);
                chk("hold_res_inv", bus.res_inv_kappa, got.inv);
                chk("hold_res_regime", 32'(bus.res_regime), 32'(got.regime));
                chk("hold_busy", 32'(bus.busy), 32'd1);
                chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
            end
            bus.req_valid = '0;
            bus.res_ready = 1'b1;
        end

        @(posedge clk); #2;
        chk("res_valid_drop", 32'(bus.res_valid), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        job_t j;
        int   rdy;

        tbl[0]  = '{4'hF, 3,  32'h0001_0000, 32'h0000_8000, 32'h0000_1111, 32'h0000_2222, REGIME_UNDER, 0};
        tbl[1]  = '{4'hF, 5,  32'h0002_0000, 32'h0000_4000, 32'h0000_3333, 32'h0000_4444, REGIME_CRIT,  1};
        tbl[2]  = '{4'hF, 2,  32'h0003_0000, 32'h0000_2000, 32'h0000_5555, 32'h0000_6666, REGIME_OVER,  2};
        tbl[3]  = '{4'hF, 1,  32'h0005_0000, 32'h0000_1000, 32'h0000_7777, 32'h0000_8888, REGIME_UNDER, 3};
        tbl[4]  = '{4'hF, 4,  32'h0006_0000, 32'h0000_0800, 32'h0000_9999, 32'h0000_AAAA, REGIME_CRIT,  0};
        tbl[5]  = '{4'h4, 10, 32'h0004_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, REGIME_UNDER, 2};
        tbl[6]  = '{4'hB, -1, 32'h0007_0000, 32'h0002_0000, 32'h1234_5678, 32'h8765_4321, REGIME_OVER,  3};
        tbl[7]  = '{4'h2, 16, 32'h0008_0000, 32'h0003_0000, 32'h0002_8000, 32'h0000_6666, REGIME_OVER,  1};
        tbl[8]  = '{4'h5, 6,  32'h0009_0000, 32'h0004_0000, 32'h0000_ABCD, 32'h0000_DCBA, REGIME_CRIT,  2};
        tbl[9]  = '{4'h1, 1,  32'h000A_0000, 32'h0005_0000, 32'h0000_0101, 32'h0000_0202, REGIME_UNDER, 0};
        tbl[10] = '{4'h8, 17, 32'h000B_0000, 32'h0006_0000, 32'hCAFE_0000, 32'h0000_CAFE, REGIME_OVER,  3};

        bus.req_valid      = '0;
        bus.req_a0         = '0;
        bus.req_a1         = '0;
        bus.res_ready      = 1'b0;
        bus.core_kappa     = '0;
        bus.core_inv_kappa = '0;
        bus.core_regime    = '0;

        repeat (3) @(posedge clk);
        #2;
        check_quiet("reset");
        rst = 1'b0;
        @(posedge clk); #2;
        check_quiet("post_reset");

        // Round-robin from reset, single request, timeout, done-at-deadline, late done.
        for (int t = 0; t < 11; t++) run_job(tbl[t], 1'b0);

        // Backpressure with a spurious done while the result is held.
        j = '{4'h2, 4, 32'h000C_0000, 32'h0007_0000, 32'h0002_3000, 32'h0000_7000, REGIME_OVER, 1};
        run_job(j, 1'b1);

        // Reset in the middle of WAIT: job is dropped, late done is ignored.
        bus.req_a0[3*32 +: 32] = 32'h000D_0000;
        bus.req_a1[3*32 +: 32] = 32'h0008_0000;
        stub_delay    = 8;
        bus.res_ready = 1'b1;
        bus.req_valid = 4'h8;
        #1;
        chk("rst_job_grant", 32'(bus.req_ready), 32'h8);
        @(posedge clk); #2;
        bus.req_valid = '0;
        rdy = cyc;
        chk("rst_job_issue", 32'(bus.core_data_rdy), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        chk("rst_job_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check_quiet("mid_wait_reset");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_quiet("after_reset");
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #2;
            chk("late_done_res_valid", 32'(bus.res_valid), 32'd0);
            chk("late_done_busy", 32'(bus.busy), 32'd0);
        end
        chk("late_done_passed", 32'(cyc - rdy > 8), 32'd1);

        j = '{4'hF, 2, 32'h000E_0000, 32'h0009_0000, 32'h0000_4242, 32'h0000_2424, REGIME_UNDER, 0};
        run_job(j, 1'b0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
